// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer: fetches instructions from a combinational ROM, hands them to decode
// with a valid/ready handshake, and stalls for NOP delay literals or redirects on branches.
module rom_fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'd0,
    parameter logic [3:0]  NOP_OPCODE   = 4'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oRomAddress,
    input  logic [27:0] iRomInstruction,
    output logic [27:0] oInstruction,
    output logic [15:0] oPC,
    output logic        oValid,
    input  logic        iReady,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic        oDelayBusy
);
    localparam logic [1:0] FETCH = 2'd0, ISSUE = 2'd1, DELAY = 2'd2;
    logic [1:0]  state;
    logic [15:0] pc;
    logic [23:0] cnt;
    logic        delay_nop;
    assign oRomAddress = pc;
    assign oDelayBusy  = state == DELAY;
    assign delay_nop   = oInstruction[27:24] == NOP_OPCODE && |oInstruction[23:0];
    // A branch overrides everything, including an acceptance in the same cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= FETCH;
            pc           <= RESET_VECTOR;
            cnt          <= 24'd0;
            oValid       <= 1'b0;
            oInstruction <= 28'd0;
            oPC          <= 16'd0;
        end else if (iBranchTaken) begin
            state  <= FETCH;
            pc     <= iBranchTarget;
            cnt    <= 24'd0;
            oValid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    oInstruction <= iRomInstruction;
                    oPC          <= pc;
                    oValid       <= 1'b1;
                    pc           <= pc + 16'd1;
                    state        <= ISSUE;
                end
                ISSUE: if (iReady) begin
                    oValid <= 1'b0;
                    cnt    <= delay_nop ? oInstruction[23:0] : 24'd0;
                    state  <= delay_nop ? DELAY : FETCH;
                end
                DELAY: begin
                    cnt   <= cnt - 24'd1;
                    state <= cnt <= 24'd1 ? FETCH : DELAY;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// tb_rom_fetch_sequencer: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model of fetch, hand-off and delay behaviour.
module tb_rom_fetch_sequencer;
    logic        Clock = 1'b0, Reset = 1'b0;
    logic [15:0] oRomAddress, oPC, iBranchTarget = 16'd0;
    logic [27:0] iRomInstruction, oInstruction;
    logic        oValid, oDelayBusy, iReady = 1'b0, iBranchTaken = 1'b0;
    logic [27:0] rom [0:255];
    int          errs = 0, checks = 0;
    logic [15:0] m_pc, m_opc;
    logic [27:0] m_instr;
    logic        m_valid;
    int          m_dly;

    rom_fetch_sequencer dut (
        .Clock(Clock), .Reset(Reset), .oRomAddress(oRomAddress),
        .iRomInstruction(iRomInstruction), .oInstruction(oInstruction), .oPC(oPC),
        .oValid(oValid), .iReady(iReady), .iBranchTaken(iBranchTaken),
        .iBranchTarget(iBranchTarget), .oDelayBusy(oDelayBusy)
    );

    assign iRomInstruction = rom[oRomAddress[7:0]];
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"}, {16'd0, oRomAddress}, {16'd0, m_pc});
        check({tag, ".valid"}, {31'd0, oValid}, {31'd0, m_valid});
        check({tag, ".busy"}, {31'd0, oDelayBusy}, {31'd0, m_dly > 0});
        check({tag, ".instr"}, {4'd0, oInstruction}, {4'd0, m_instr});
        check({tag, ".pc"}, {16'd0, oPC}, {16'd0, m_opc});
    endtask

    // Behaviour seen by the outside: either an instruction is offered, a delay is
    // counting down, or the next ROM word is fetched.
    task automatic model_edge(input logic rdy, input logic br, input logic [15:0] tgt);
        if (br) begin
            m_pc = tgt; m_valid = 1'b0; m_dly = 0;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                m_dly = (m_instr[27:24] == 4'd0) ? int'(m_instr[23:0]) : 0;
            end
        end else if (m_dly > 0) begin
            m_dly--;
        end else begin
            m_instr = rom[m_pc[7:0]]; m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic cycle(input string tag, input logic rdy, input logic br, input logic [15:0] tgt);
        iReady = rdy; iBranchTaken = br; iBranchTarget = tgt;
        @(posedge Clock);
        model_edge(rdy, br, tgt);
        @(negedge Clock);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b0;
        #1;
        m_pc = 16'd0; m_opc = 16'd0; m_instr = 28'd0; m_valid = 1'b0; m_dly = 0;
        check_all(tag);
        iReady = 1'b0; iBranchTaken = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            rom[i] = {op, op == 4'd0 ? 24'($urandom_range(0, 12)) : 24'($urandom)};
        end
    endtask

    initial begin
        fill_rom();
        @(negedge Clock);
        do_reset("rst0");
        // STO, STO, ADD back to back
        rom[0] = {4'd1, 24'h000011}; rom[1] = {4'd1, 24'h000022}; rom[2] = {4'd2, 24'h000033};
        rom[3] = {4'd2, 24'h000044};
        for (int i = 0; i < 6; i++) cycle("seq", 1'b1, 1'b0, 16'd0);
        // long NOP delay, then branch out of a second one mid-count
        do_reset("rst1");
        rom[0] = {4'd0, 24'd4000};
        for (int i = 0; i < 4006; i++) cycle("nop4000", 1'b1, 1'b0, 16'd0);
        do_reset("rst2");
        while (m_dly != 2500 && checks < 60000) cycle("to2500", 1'b1, 1'b0, 16'd0);
        check("reach2500", m_dly, 2500);
        cycle("br_dly", 1'b1, 1'b1, 16'd8);
        for (int i = 0; i < 3; i++) cycle("after_br", 1'b1, 1'b0, 16'd0);
        // stall with a STO held at oPC=3
        do_reset("rst3");
        rom[0] = {4'd1, 24'h1}; rom[1] = {4'd1, 24'h2}; rom[2] = {4'd3, 24'h3}; rom[3] = {4'd1, 24'h4};
        for (int i = 0; i < 7; i++) cycle("pre_stall", 1'b1, 1'b0, 16'd0);
        cycle("fetch3", 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            rom[4] = 28'($urandom);
            cycle("stall", 1'b0, 1'b0, 16'd0);
        end
        cycle("release", 1'b1, 1'b0, 16'd0);
        // JMP accepted in the same cycle as a redirect
        rom[14] = {4'd5, 24'h00000e};
        cycle("to14", 1'b0, 1'b1, 16'd14);
        cycle("fetch14", 1'b0, 1'b0, 16'd0);
        cycle("jmp", 1'b1, 1'b1, 16'd2);
        for (int i = 0; i < 2; i++) cycle("post_jmp", 1'b1, 1'b0, 16'd0);
        // address wrap and asynchronous reset in the middle of ISSUE
        rom[255] = {4'd7, 24'h0000ff};
        cycle("to_ffff", 1'b1, 1'b1, 16'hffff);
        for (int i = 0; i < 3; i++) cycle("wrap", 1'b1, 1'b0, 16'd0);
        cycle("hold", 1'b0, 1'b0, 16'd0);
        check("in_issue", {31'd0, m_valid}, 32'd1);
        do_reset("rst_mid");
        // random traffic
        fill_rom();
        for (int i = 0; i < 3000; i++)
            cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 16'($urandom));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rom_fetch_sequencer.md
ROM_FETCH_SEQUENCER -- requirements
Module: rom_fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'd0: first instruction address after reset.
REQ-002 Parameter NOP_OPCODE, default 4'd0: encoding of the NOP opcode field, instruction bits [27:24].
REQ-003 Port Clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1: asynchronous, active-low reset.
REQ-005 Port oRomAddress  output  16: instruction ROM address; drives ROM iAddress.
REQ-006 Port iRomInstruction  input  28: combinational ROM data for oRomAddress, valid the same cycle.
REQ-007 Port oInstruction  output  28: registered instruction presented to decode.
REQ-008 Port oPC  output  16: address the current oInstruction was fetched from.
REQ-009 Port oValid  output  1: oInstruction/oPC valid.
REQ-010 Port iReady  input  1: decode accepts; a transfer occurs when oValid and iReady are both 1 at a rising edge.
REQ-011 Port iBranchTaken  input  1: one-cycle redirect request (BLE taken, JMP).
REQ-012 Port iBranchTarget  input  16: redirect address, sampled only when iBranchTaken is 1.
REQ-013 Port oDelayBusy  output  1: high while a NOP delay count is running.

Function
REQ-014 The block SHALL hold a 16-bit PC register; oRomAddress SHALL equal PC combinationally.
REQ-015 The FSM SHALL have exactly three states: FETCH, ISSUE, DELAY.
REQ-016 FETCH: capture iRomInstruction into oInstruction, PC into oPC; set oValid=1; PC <= PC+1; go to ISSUE.
REQ-017 ISSUE: hold oInstruction, oPC and oValid=1 stable until a transfer occurs.
REQ-018 On a transfer, if oInstruction[27:24]==NOP_OPCODE and oInstruction[23:0]!=0: clear oValid, load the 24-bit delay counter with oInstruction[23:0], go to DELAY.
REQ-019 On a transfer of any other instruction, including NOP with zero literal: clear oValid, go to FETCH.
REQ-020 DELAY: decrement the counter each cycle, oDelayBusy=1; when the counter equals 1, go to FETCH. A NOP literal N therefore adds exactly N cycles between its transfer and the next FETCH.
REQ-021 Throughput with iReady held at 1 and no NOP delay: one instruction per 2 cycles (FETCH, ISSUE alternating).
REQ-022 iBranchTaken=1 in any state: PC <= iBranchTarget, oValid <= 0, delay counter <= 0, oDelayBusy <= 0, next state FETCH.
REQ-023 Branch has priority over every other transition. If a transfer and iBranchTaken occur in the same cycle, the instruction counts as accepted and the redirect still applies.
REQ-024 PC increment SHALL wrap modulo 2^16 (16'hFFFF+1 = 16'h0000) with no error flag.
REQ-025 oInstruction and oPC SHALL change only in FETCH or on reset.
REQ-026 iRomInstruction SHALL be ignored outside FETCH.

Reset
REQ-027 Reset=0 asynchronously forces: PC=RESET_VECTOR, state=FETCH, oValid=0, oInstruction=28'd0, oPC=16'd0, delay counter=0, oDelayBusy=0.
REQ-028 Reset asserted mid-ISSUE or mid-DELAY SHALL discard the pending instruction and count with no transfer.
REQ-029 First rising edge after reset release SHALL fetch ROM[RESET_VECTOR]; oValid=1 after that edge.

Verification
REQ-030 Reset release, iReady=1, ROM[0..2] = STO, STO, ADD (non-NOP) -> oPC sequence 0,1,2 with oValid high every other cycle; oRomAddress 0,1,2,3.
REQ-031 ROM[0] = NOP with literal 24'd4000 transferred -> oDelayBusy high exactly 4000 cycles, then FETCH of address 1; oValid=0 throughout the delay.
REQ-032 iReady=0 for 10 cycles in ISSUE holding a STO at oPC=3 -> oInstruction, oPC, oValid unchanged; PC stays 4; no ROM data captured.
REQ-033 iBranchTaken=1, iBranchTarget=16'd8 during DELAY with counter 2500 -> next cycle oValid=0, oDelayBusy=0, state FETCH; following edge oPC=8.
REQ-034 Same-cycle transfer of JMP at oPC=14 and iBranchTaken with target 2 -> next fetched oPC=2, never 15.
REQ-035 PC=16'hFFFF fetched and transferred -> next oPC=16'h0000; Reset pulsed low mid-ISSUE -> all outputs at REQ-027 values immediately, without waiting for a Clock edge.
